// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: matrix keypad pins plus the decoded key outputs.
// master = the scanner, slave = a consumer (matrix model / downstream logic).
interface keypad_scanner_if;
  logic [3:0] key_row;    // active-low rows, pulled up externally
  logic [2:0] key_col;    // active-low columns, one low at a time
  logic [9:0] keypad;     // one-hot held digit
  logic       sharp;      // '#' held
  logic       star;       // '*' held
  logic [3:0] key_code;   // 0-9, 10 = '*', 11 = '#', 15 = none
  logic       key_press;  // one-cycle strobe on a newly accepted key

  modport master (
    input  key_row,
    output key_col, keypad, sharp, star, key_code, key_press
  );

  modport slave (
    output key_row,
    input  key_col, keypad, sharp, star, key_code, key_press
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: active 4x3 matrix scanner with ghost rejection and
// frame-based debounce. Columns are driven low in turn; rows are sampled on
// the last slot of each column. A frame (three columns) yields one code,
// and a code must repeat for DEBOUNCE_FRAMES frames before it is accepted.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (digit auto-repeat strobes).
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 100
) (
  input  logic             clock,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [3:0]    CODE_STAR  = 4'd10;
  localparam logic [3:0]    CODE_SHARP = 4'd11;
  localparam logic [3:0]    CODE_NONE  = 4'd15;

  typedef enum logic [1:0] {COL0 = 2'd0, COL1 = 2'd1, COL2 = 2'd2} col_e;

  col_e            col_q, col_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [2:0]      key_col_q, key_col_d;
  logic [1:0]      hits_q, hits_d;
  logic [3:0]      last_q, last_d;
  logic [3:0]      cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      stable_q, stable_d;
  logic [9:0]      keypad_q;
  logic            sharp_q, star_q, key_press_q;
  logic [3:0]      key_code_q;

  logic            sample_s, frame_end_s, rep_pulse_s;
  logic [2:0]      row_hits_s, hit_sum_s;
  logic [3:0]      row_code_s, frame_code_s;
  logic [1:0]      frame_hits_s;

  // Physical key at (row, column) of the 4x3 matrix.
  function automatic logic [3:0] key_map(input logic [1:0] row, input col_e col);
    logic [3:0] code;
    case (row)
      2'd0, 2'd1, 2'd2: code = 4'({2'b00, row} * 4'd3) + 4'({2'b00, col}) + 4'd1;
      2'd3: begin
        case (col)
          COL0:    code = CODE_STAR;
          COL1:    code = 4'd0;
          COL2:    code = CODE_SHARP;
          default: code = CODE_NONE;
        endcase
      end
      default: code = CODE_NONE;
    endcase
    return code;
  endfunction

  // One-hot level for a digit code; other codes give all zeros.
  function automatic logic [9:0] digit_onehot(input logic [3:0] code);
    logic [9:0] v;
    if (code <= 4'd9) v = 10'd1 << code;
    else              v = 10'd0;
    return v;
  endfunction

  // Column scan FSM: hold each column for SCAN_DIV cycles, sample on the last.
  always_comb begin
    slot_d    = slot_q;
    col_d     = col_q;
    key_col_d = key_col_q;
    sample_s  = (slot_q == SLOT_LAST);
    if (sample_s) begin
      slot_d = {SW{1'b0}};
      case (col_q)
        COL0:    begin col_d = COL1; key_col_d = 3'b101; end
        COL1:    begin col_d = COL2; key_col_d = 3'b011; end
        COL2:    begin col_d = COL0; key_col_d = 3'b110; end
        default: begin col_d = COL0; key_col_d = 3'b110; end
      endcase
    end else begin
      slot_d = slot_q + SW'(1);
    end
    frame_end_s = sample_s && (col_q == COL2);
  end

  // Per-sample row decode and per-frame hit accumulation (saturating at 2).
  always_comb begin
    row_hits_s = 3'd0;
    row_code_s = CODE_NONE;
    for (int r = 0; r < 4; r++) begin
      if (kp.key_row[r] == 1'b0) begin
        row_hits_s = row_hits_s + 3'd1;
        row_code_s = key_map(2'(r), col_q);
      end else begin
        row_hits_s = row_hits_s;
      end
    end
    hit_sum_s    = {1'b0, hits_q} + row_hits_s;
    frame_hits_s = (hit_sum_s >= 3'd2) ? 2'd2 : hit_sum_s[1:0];
    if (frame_hits_s == 2'd1) begin
      frame_code_s = (row_hits_s != 3'd0) ? row_code_s : last_q;
    end else begin
      frame_code_s = CODE_NONE;  // no key, or ghosting / multi-press
    end
    hits_d = hits_q;
    last_d = last_q;
    if (frame_end_s) begin
      hits_d = 2'd0;
      last_d = CODE_NONE;
    end else if (sample_s) begin
      hits_d = frame_hits_s;
      last_d = (row_hits_s != 3'd0) ? row_code_s : last_q;
    end else begin
      hits_d = hits_q;
    end
  end

  // Debounce: accept a candidate once it has been seen DEBOUNCE_FRAMES frames running.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (frame_end_s) begin
      if (frame_code_s == cand_q) begin
        cnt_d = (cnt_q >= CNT_FULL) ? CNT_FULL : cnt_q + CW'(1);
      end else begin
        cand_d = frame_code_s;
        cnt_d  = CNT_ONE;
      end
      if ((cnt_d == CNT_FULL) && (cand_d != stable_q)) stable_d = cand_d;
      else                                             stable_d = stable_q;
    end else begin
      stable_d = stable_q;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_req_q, rep_req_d;

  // Auto-repeat: count frame ends while a digit stays stable, request a strobe.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_req_d = 1'b0;
    if (frame_end_s) begin
      if (stable_d != stable_q) begin
        rep_cnt_d = {RW{1'b0}};
      end else if (stable_q <= 4'd9) begin
        if (rep_cnt_q >= REP_LAST) begin
          rep_cnt_d = {RW{1'b0}};
          rep_req_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end else begin
        rep_cnt_d = {RW{1'b0}};
      end
    end else begin
      rep_cnt_d = rep_cnt_q;
    end
  end

  // Auto-repeat state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_cnt_q <= {RW{1'b0}};
      rep_req_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_req_q <= rep_req_d;
    end
  end

  assign rep_pulse_s = rep_req_q;
`else
  assign rep_pulse_s = 1'b0;
`endif

  // Scan, accumulator and debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q     <= COL0;
      slot_q    <= {SW{1'b0}};
      key_col_q <= 3'b110;
      hits_q    <= 2'd0;
      last_q    <= CODE_NONE;
      cand_q    <= CODE_NONE;
      cnt_q     <= {CW{1'b0}};
      stable_q  <= CODE_NONE;
    end else begin
      col_q     <= col_d;
      slot_q    <= slot_d;
      key_col_q <= key_col_d;
      hits_q    <= hits_d;
      last_q    <= last_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
    end
  end

  // Registered decode of the stable key; key_code_q still holds the previous
  // stable value for one cycle, which marks the change for the press strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      keypad_q    <= 10'd0;
      sharp_q     <= 1'b0;
      star_q      <= 1'b0;
      key_code_q  <= CODE_NONE;
      key_press_q <= 1'b0;
    end else begin
      keypad_q    <= digit_onehot(stable_q);
      sharp_q     <= (stable_q == CODE_SHARP);
      star_q      <= (stable_q == CODE_STAR);
      key_code_q  <= stable_q;
      key_press_q <= ((stable_q != key_code_q) && (stable_q != CODE_NONE)) || rep_pulse_s;
    end
  end

  assign kp.key_col   = key_col_q;
  assign kp.keypad    = keypad_q;
  assign kp.sharp     = sharp_q;
  assign kp.star      = star_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_press = key_press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4,
// DEBOUNCE_FRAMES=3, REPEAT_FRAMES=2 (frame = 12 cycles). A small matrix
// model turns the set of pressed keys into active-low rows for the column
// currently driven. Honours KEYPAD_AUTOREPEAT_EN for the repeat step.
module tb_keypad_scanner;
  logic        clock;
  logic        reset;
  logic [11:0] pressed;   // bit n = key code n held (10 = '*', 11 = '#')
  logic [3:0]  row_s;
  int          press_cnt;
  int          n_chk;
  int          n_err;
  int          snap;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (3),
    .REPEAT_FRAMES   (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Key printed at (row, column) of the physical pad.
  function automatic int key_at(input int r, input int c);
    int lut [0:11];
    lut = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
    return lut[r * 3 + c];
  endfunction

  // Matrix model: a row reads low when a held key sits on it in a driven column.
  always_comb begin
    row_s = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (kp.key_col[c] == 1'b0 && pressed[key_at(r, c)] == 1'b1) row_s[r] = 1'b0;
      end
    end
  end
  assign kp.key_row = row_s;

  // Strobe counter, sampled on the falling edge.
  always @(negedge clock) begin
    if (kp.key_press === 1'b1) press_cnt <= press_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reset with the given keys held; returns at the negedge where k = 0
  // (state is col0 slot0, the first cycle of frame 0).
  task automatic restart(input logic [11:0] keys);
    @(negedge clock);
    reset   = 1'b1;
    pressed = keys;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_col;
    n_chk = 0;
    n_err = 0;
    press_cnt = 0;
    reset = 1'b1;
    pressed = 12'd0;
    tick(3);

    // 1. Reset values and idle scanning
    chk("rst_key_col", 32'(kp.key_col), 32'(3'b110));
    chk("rst_keypad", 32'(kp.keypad), 32'd0);
    chk("rst_key_code", 32'(kp.key_code), 32'd15);
    chk("rst_key_press", 32'(kp.key_press), 32'd0);
    chk("rst_sharp_star", 32'({kp.sharp, kp.star}), 32'd0);
    restart(12'd0);
    snap = press_cnt;
    for (int k = 0; k < 24; k++) begin
      case ((k / 4) % 3)
        0:       exp_col = 3'b110;
        1:       exp_col = 3'b101;
        default: exp_col = 3'b011;
      endcase
      chk("scan_col", 32'(kp.key_col), 32'(exp_col));
      tick(1);
    end
    tick(76);
    chk("idle_keypad", 32'(kp.keypad), 32'd0);
    chk("idle_key_code", 32'(kp.key_code), 32'd15);
    chk("idle_no_strobe", 32'(press_cnt - snap), 32'd0);

    // 2. Clean '5' press and release
    restart(12'd1 << 5);
    snap = press_cnt;
    tick(36);
    chk("p5_before", 32'(kp.key_code), 32'd15);
    tick(1);
    chk("p5_keypad", 32'(kp.keypad), 32'(10'b0000100000));
    chk("p5_key_code", 32'(kp.key_code), 32'd5);
    chk("p5_strobe", 32'(kp.key_press), 32'd1);
    tick(1);
    chk("p5_strobe_end", 32'(kp.key_press), 32'd0);
    tick(10);                 // k = 48, frame start
    pressed = 12'd0;
    tick(36);                 // k = 84
    chk("r5_still_held", 32'(kp.key_code), 32'd5);
    tick(1);                  // k = 85
    chk("r5_key_code", 32'(kp.key_code), 32'd15);
    chk("r5_keypad", 32'(kp.keypad), 32'd0);
    tick(2);
    chk("r5_one_strobe", 32'(press_cnt - snap), 32'd1);

    // 3. '#' with bounce: present, absent, then stable
    restart(12'd1 << 11);
    snap = press_cnt;
    tick(12);
    pressed = 12'd0;
    tick(12);
    pressed = 12'd1 << 11;
    tick(24);                 // k = 48
    chk("sh_not_yet", 32'(kp.sharp), 32'd0);
    tick(12);                 // k = 60
    chk("sh_before", 32'(kp.sharp), 32'd0);
    tick(1);                  // k = 61
    chk("sh_sharp", 32'(kp.sharp), 32'd1);
    chk("sh_key_code", 32'(kp.key_code), 32'd11);
    chk("sh_star", 32'(kp.star), 32'd0);
    chk("sh_strobe", 32'(kp.key_press), 32'd1);
    tick(2);
    chk("sh_one_strobe", 32'(press_cnt - snap), 32'd1);

    // 4. Ghosting: '1' and '2' together, then drop '2'
    restart((12'd1 << 1) | (12'd1 << 2));
    snap = press_cnt;
    tick(48);
    chk("gh_key_code", 32'(kp.key_code), 32'd15);
    chk("gh_keypad", 32'(kp.keypad), 32'd0);
    chk("gh_no_strobe", 32'(press_cnt - snap), 32'd0);
    pressed = 12'd1 << 1;
    tick(36);                 // k = 84
    chk("gh_not_yet", 32'(kp.key_code), 32'd15);
    tick(1);                  // k = 85
    chk("gh_one_key", 32'(kp.key_code), 32'd1);
    chk("gh_one_keypad", 32'(kp.keypad), 32'(10'b0000000010));

    // 5. Reset shortly after '7' is accepted
    restart(12'd1 << 7);
    tick(37);
    chk("r7_accept", 32'(kp.key_code), 32'd7);
    tick(4);                  // reset visible to the edge 5 cycles after acceptance
    reset = 1'b1;
    tick(1);
    chk("r7_rst_keypad", 32'(kp.keypad), 32'd0);
    chk("r7_rst_key_code", 32'(kp.key_code), 32'd15);
    chk("r7_rst_key_col", 32'(kp.key_col), 32'(3'b110));
    tick(1);
    reset = 1'b0;
    tick(36);
    chk("r7_re_before", 32'(kp.key_code), 32'd15);
    tick(1);
    chk("r7_re_key_code", 32'(kp.key_code), 32'd7);
    chk("r7_re_keypad", 32'(kp.keypad), 32'(10'b0010000000));

    // 6. Hold '0' for 10 frames (auto-repeat when enabled)
    restart(12'd1);
    snap = press_cnt;
    tick(37);
    chk("ar_accept", 32'(kp.key_code), 32'd0);
    chk("ar_first_strobe", 32'(kp.key_press), 32'd1);
    tick(24);                 // k = 61
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("ar_repeat_strobe", 32'(kp.key_press), 32'd1);
`else
    chk("ar_no_repeat", 32'(kp.key_press), 32'd0);
`endif
    tick(59);                 // k = 120
    pressed = 12'd0;
    tick(40);                 // k = 160
    chk("ar_released", 32'(kp.key_code), 32'd15);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("ar_strobe_count", 32'(press_cnt - snap), 32'd5);
`else
    chk("ar_strobe_count", 32'(press_cnt - snap), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
